// File: rtl/register_file_if.sv
// Bus bundle between the processor pipeline and the register file: two read ports,
// one write port, debug read and status.
interface register_file_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] register_file_read_address_1;
  logic [ADDR_WIDTH-1:0] register_file_read_address_2;
  logic [31:0]           register_file_read_value_1;
  logic [31:0]           register_file_read_value_2;
  logic [ADDR_WIDTH-1:0] register_file_write_address;
  logic [31:0]           register_file_write_value;
  // No ready exists: a write is taken at the edge where write_enable is high,
  // unless busy is high, and then it is dropped.
  logic                  register_file_write_enable;
  logic [ADDR_WIDTH-1:0] debug_address;
  logic [31:0]           debug_value;
  logic [15:0]           write_count;
  logic                  busy;
  logic                  debug_state;

  modport master (
    output register_file_read_address_1, register_file_read_address_2,
    output register_file_write_address, register_file_write_value,
    output register_file_write_enable, debug_address,
    input  register_file_read_value_1, register_file_read_value_2,
    input  debug_value, write_count, busy, debug_state
  );

  modport slave (
    input  register_file_read_address_1, register_file_read_address_2,
    input  register_file_write_address, register_file_write_value,
    input  register_file_write_enable, debug_address,
    output register_file_read_value_1, register_file_read_value_2,
    output debug_value, write_count, busy, debug_state
  );
endinterface

// File: rtl/register_file.sv
// Two-read/one-write register file with write bypass, r0 hardwired to zero,
// a reset-time clear sequencer, a registered debug port and a saturating write counter.
module register_file #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input logic            clock,
  input logic            reset,
  register_file_if.slave bus
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] clear_index;
  logic [31:0]           entries [DEPTH];
  logic [15:0]           write_count_q;
  logic [31:0]           debug_value_q;
  logic                  write_commit;

  assign write_commit = (state == READY) && bus.register_file_write_enable &&
                        (bus.register_file_write_address != '0);

  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == CLEAR && clear_index == ADDR_WIDTH'(DEPTH - 1)) next_state = READY;
  end

  always_ff @(posedge clock) begin
    if (reset)                clear_index <= '0;
    else if (state == CLEAR)  clear_index <= clear_index + ADDR_WIDTH'(1);
  end

  // Storage has no reset of its own; the clear sequence zeroes it before any read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)    entries[clear_index] <= '0;
      else if (write_commit) entries[bus.register_file_write_address] <= bus.register_file_write_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_count_q <= '0;
    end else if (write_commit && write_count_q != 16'hFFFF) begin
      write_count_q <= write_count_q + 16'd1;
    end
  end

  // Debug sees stored contents only, so a same-cycle write is not visible here.
  always_ff @(posedge clock) begin
    if (reset || state == CLEAR || bus.debug_address == '0) debug_value_q <= '0;
    else                                                     debug_value_q <= entries[bus.debug_address];
  end

  always_comb begin
    bus.busy        = (state == CLEAR);
    bus.debug_state = (state == READY);
    bus.debug_value = debug_value_q;
    bus.write_count = write_count_q;

    bus.register_file_read_value_1 = '0;
    if (state == READY && bus.register_file_read_address_1 != '0) begin
      if (bus.register_file_write_enable &&
          bus.register_file_write_address == bus.register_file_read_address_1)
        bus.register_file_read_value_1 = bus.register_file_write_value;
      else
        bus.register_file_read_value_1 = entries[bus.register_file_read_address_1];
    end

    bus.register_file_read_value_2 = '0;
    if (state == READY && bus.register_file_read_address_2 != '0) begin
      if (bus.register_file_write_enable &&
          bus.register_file_write_address == bus.register_file_read_address_2)
        bus.register_file_read_value_2 = bus.register_file_write_value;
      else
        bus.register_file_read_value_2 = entries[bus.register_file_read_address_2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: clear sequence, writes, bypass, r0, debug port,
// reset restart and counter saturation.
module tb_register_file;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] exp_count;
  logic [31:0] exp_q[$];

  register_file_if #(.ADDR_WIDTH(6)) bus ();

  register_file #(.DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.register_file_write_enable   = 1'b0;
    bus.register_file_write_address  = '0;
    bus.register_file_write_value    = '0;
    bus.register_file_read_address_1 = '0;
    bus.register_file_read_address_2 = '0;
    bus.debug_address                = '0;
  endtask

  // Pulses reset for one edge, then counts edges until busy falls; a write is
  // attempted on clear edge 10.
  task automatic run_clear(input string tag);
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 16'd0;
    total++;
    if (bus.busy !== 1'b1 || bus.write_count !== 16'd0 || bus.debug_value !== 32'd0) begin
      bad++;
      $display("FAIL %s_after_reset: busy=%b count=%h debug=%h want 1/0000/00000000",
               tag, bus.busy, bus.write_count, bus.debug_value);
    end
    n = 0;
    while (n < 200) begin
      if (n == 9) begin
        bus.register_file_write_enable  = 1'b1;
        bus.register_file_write_address = 6'd3;
        bus.register_file_write_value   = 32'hAAAA5555;
        bus.register_file_read_address_1 = 6'd3;
        bus.register_file_read_address_2 = 6'd9;
        #1;
        total++;
        if (bus.register_file_read_value_1 !== 32'd0 || bus.register_file_read_value_2 !== 32'd0) begin
          bad++;
          $display("FAIL %s_read_in_clear: r1=%h r2=%h want 0/0", tag,
                   bus.register_file_read_value_1, bus.register_file_read_value_2);
        end
      end
      step();
      bus.register_file_write_enable = 1'b0;
      n++;
      if (bus.busy !== 1'b1) break;
    end
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL %s_clear_length: busy edges=%0d want 64", tag, n);
    end
    bus.register_file_read_address_1 = 6'd3;
    bus.register_file_read_address_2 = 6'd63;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'd0 || bus.register_file_read_value_2 !== 32'd0 ||
        bus.write_count !== 16'd0) begin
      bad++;
      $display("FAIL %s_after_clear: r3=%h r63=%h count=%h want 0/0/0", tag,
               bus.register_file_read_value_1, bus.register_file_read_value_2, bus.write_count);
    end
  endtask

  task automatic test_reset();
    run_clear("reset");
  endtask

  task automatic test_write();
    bus.register_file_write_enable  = 1'b1;
    bus.register_file_write_address = 6'd5;
    bus.register_file_write_value   = 32'hDEADBEEF;
    step();
    exp_count++;
    bus.register_file_write_enable   = 1'b0;
    bus.register_file_read_address_1 = 6'd5;
    bus.debug_address                = 6'd5;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'hDEADBEEF || bus.write_count !== exp_count) begin
      bad++;
      $display("FAIL write_5: r1=%h count=%h want deadbeef/%h",
               bus.register_file_read_value_1, bus.write_count, exp_count);
    end
    step();
    total++;
    if (bus.debug_value !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL debug_5: got %h want deadbeef", bus.debug_value);
    end
  endtask

  task automatic test_bypass();
    bus.register_file_write_enable   = 1'b1;
    bus.register_file_write_address  = 6'd7;
    bus.register_file_write_value    = 32'h12345678;
    bus.register_file_read_address_1 = 6'd7;
    bus.register_file_read_address_2 = 6'd7;
    bus.debug_address                = 6'd7;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'h12345678 || bus.register_file_read_value_2 !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_both: r1=%h r2=%h want 12345678", bus.register_file_read_value_1,
               bus.register_file_read_value_2);
    end
    step();
    exp_count++;
    bus.register_file_write_enable = 1'b0;
    total++;
    if (bus.debug_value !== 32'd0 || bus.write_count !== exp_count) begin
      bad++;
      $display("FAIL debug_no_bypass: debug=%h count=%h want 00000000/%h", bus.debug_value,
               bus.write_count, exp_count);
    end
    step();
    total++;
    if (bus.debug_value !== 32'h12345678) begin
      bad++;
      $display("FAIL debug_7: got %h want 12345678", bus.debug_value);
    end
    // Ports resolve independently: one hits storage, the other the bypass.
    bus.register_file_write_enable   = 1'b1;
    bus.register_file_write_address  = 6'd7;
    bus.register_file_write_value    = 32'h0BADF00D;
    bus.register_file_read_address_1 = 6'd5;
    bus.register_file_read_address_2 = 6'd7;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'hDEADBEEF || bus.register_file_read_value_2 !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL bypass_mixed: r1=%h r2=%h want deadbeef/0badf00d",
               bus.register_file_read_value_1, bus.register_file_read_value_2);
    end
    step();
    exp_count++;
    bus.register_file_write_enable = 1'b0;
  endtask

  task automatic test_zero_write();
    bus.register_file_write_enable   = 1'b1;
    bus.register_file_write_address  = 6'd0;
    bus.register_file_write_value    = 32'hFFFFFFFF;
    bus.register_file_read_address_1 = 6'd0;
    bus.register_file_read_address_2 = 6'd0;
    bus.debug_address                = 6'd0;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'd0 || bus.register_file_read_value_2 !== 32'd0) begin
      bad++;
      $display("FAIL r0_bypass: r1=%h r2=%h want 0/0", bus.register_file_read_value_1,
               bus.register_file_read_value_2);
    end
    step();
    bus.register_file_write_enable = 1'b0;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'd0 || bus.write_count !== exp_count || bus.debug_value !== 32'd0) begin
      bad++;
      $display("FAIL r0_write: r0=%h count=%h debug=%h want 0/%h/0", bus.register_file_read_value_1,
               bus.write_count, exp_count, bus.debug_value);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] want;
    for (int i = 0; i < 4; i++) begin
      v = 32'hC0DE0000 + 32'(i * 17);
      bus.register_file_write_enable  = 1'b1;
      bus.register_file_write_address = 6'(10 + i);
      bus.register_file_write_value   = v;
      exp_q.push_back(v);
      step();
      exp_count++;
    end
    bus.register_file_write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want = exp_q.pop_front();
      bus.register_file_read_address_1 = 6'(10 + i);
      bus.register_file_read_address_2 = 6'(13 - i);
      #1;
      total++;
      if (bus.register_file_read_value_1 !== want) begin
        bad++;
        $display("FAIL b2b_read_%0d: got %h want %h", 10 + i, bus.register_file_read_value_1, want);
      end
    end
    total++;
    if (bus.write_count !== exp_count) begin
      bad++;
      $display("FAIL b2b_count: got %h want %h", bus.write_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_ready();
    step();
    run_clear("rerun");
    bus.register_file_read_address_1 = 6'd5;
    bus.register_file_read_address_2 = 6'd7;
    bus.debug_address                = 6'd12;
    #1;
    total++;
    if (bus.register_file_read_value_1 !== 32'd0 || bus.register_file_read_value_2 !== 32'd0) begin
      bad++;
      $display("FAIL rerun_entries: r5=%h r7=%h want 0/0", bus.register_file_read_value_1,
               bus.register_file_read_value_2);
    end
    step();
    total++;
    if (bus.debug_value !== 32'd0) begin
      bad++;
      $display("FAIL rerun_debug: got %h want 0", bus.debug_value);
    end
  endtask

  task automatic test_saturation();
    bus.register_file_write_enable  = 1'b1;
    bus.register_file_write_address = 6'd1;
    for (int i = 0; i < 65534; i++) begin
      bus.register_file_write_value = 32'(i);
      step();
    end
    total++;
    if (bus.write_count !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_fffe: got %h want fffe", bus.write_count);
    end
    step();
    total++;
    if (bus.write_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_ffff: got %h want ffff", bus.write_count);
    end
    for (int i = 0; i < 5; i++) begin
      bus.register_file_write_value = 32'h5A5A0000 + 32'(i);
      step();
    end
    bus.register_file_write_enable   = 1'b0;
    bus.register_file_read_address_1 = 6'd1;
    #1;
    total++;
    if (bus.write_count !== 16'hFFFF || bus.register_file_read_value_1 !== 32'h5A5A0004) begin
      bad++;
      $display("FAIL sat_hold: count=%h r1=%h want ffff/5a5a0004", bus.write_count,
               bus.register_file_read_value_1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_count = 16'd0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_bypass();
    test_zero_write();
    test_back_to_back();
    test_reset_mid_ready();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
